// File: rtl/block_hit_ctrl_if.sv
// Ball-hit query handshake between the physics logic (master) and block_hit_ctrl (slave).
interface block_hit_ctrl_if;
  logic       hit_req;
  logic [3:0] hit_row;
  logic [3:0] hit_col;
  logic       hit_ready;
  logic       hit_done;
  logic       hit_block;

  modport master (
    output hit_req, hit_row, hit_col,
    input  hit_ready, hit_done, hit_block
  );

  modport slave (
    input  hit_req, hit_row, hit_col,
    output hit_ready, hit_done, hit_block
  );
endinterface

// File: rtl/block_hit_ctrl.sv
// Sequencer driving block_state: seeks the target row, tests/clears one bit, reports hit/miss.
// Optional remaining-block counter and level_clear enabled by defining BLOCK_HIT_COUNT_EN.
module block_hit_ctrl #(
  parameter int NUM_ROWS       = 15,
  parameter int INITIAL_BLOCKS = 91
) (
  input  logic                   clk,
  input  logic                   nRst,
  block_hit_ctrl_if.slave        hit,
  output logic [6:0]             blocks_left,
  output logic                   level_clear,
  input  logic [12:0]            line,
  output logic [12:0]            new_line,
  output logic                   write_line,
  output logic                   next_line
);

  typedef enum logic [1:0] {IDLE, SEEK, CHECK} state_t;

  localparam logic [3:0] LAST_ROW = 4'(NUM_ROWS - 1);

  state_t      state, state_nxt;
  logic [3:0]  cur_row;
  logic [3:0]  tgt_row;
  logic [3:0]  tgt_col;
  logic        tgt_oor;
  logic        accept;
  logic        in_range;
  logic        blk;
  logic [12:0] col_mask;

  assign accept   = hit.hit_req && (state == IDLE);
  assign in_range = ({1'b0, hit.hit_row} < 5'(NUM_ROWS)) && (hit.hit_col <= 4'd12);
  // A column beyond 12 shifts the mask to zero, so no bit can be read or cleared.
  assign col_mask = 13'd1 << tgt_col;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = in_range ? SEEK : CHECK;
      SEEK:    if (cur_row == tgt_row) state_nxt = CHECK;
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    hit.hit_ready = 1'b0;
    hit.hit_done  = 1'b0;
    blk           = 1'b0;
    write_line    = 1'b0;
    next_line     = 1'b0;
    new_line      = 13'd0;
    unique case (state)
      IDLE: hit.hit_ready = 1'b1;
      SEEK: next_line     = (cur_row != tgt_row);
      CHECK: begin
        hit.hit_done = 1'b1;
        blk          = !tgt_oor && |(line & col_mask);
        write_line   = blk;
        new_line     = blk ? (line & ~col_mask) : line;
      end
      default: ;
    endcase
  end

  assign hit.hit_block = blk;

  // cur_row shadows block_state's rotation pointer; both reset together on nRst.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      cur_row <= 4'd0;
      tgt_row <= 4'd0;
      tgt_col <= 4'd0;
      tgt_oor <= 1'b0;
    end else begin
      if (next_line) cur_row <= (cur_row == LAST_ROW) ? 4'd0 : cur_row + 4'd1;
      if (accept) begin
        tgt_row <= hit.hit_row;
        tgt_col <= hit.hit_col;
        tgt_oor <= !in_range;
      end
    end
  end

`ifdef BLOCK_HIT_COUNT_EN
  logic [6:0] left_cnt;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst)                         left_cnt <= 7'(INITIAL_BLOCKS);
    else if (blk && left_cnt != 7'd0)  left_cnt <= left_cnt - 7'd1;
  end

  assign blocks_left = left_cnt;
  assign level_clear = (left_cnt == 7'd0);
`else
  assign blocks_left = 7'd0;
  assign level_clear = 1'b0;
`endif

endmodule

// File: tb/tb_block_hit_ctrl.sv
// Randomized scoreboard bench for block_hit_ctrl with a behavioural block_state and grid model.
module tb_block_hit_ctrl;
  localparam int NR   = 15;
  localparam int INIT = 91;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic [12:0] line, new_line;
  logic        write_line, next_line, level_clear;
  logic [6:0]  blocks_left;

  block_hit_ctrl_if hif();

  block_hit_ctrl #(.NUM_ROWS(NR), .INITIAL_BLOCKS(INIT)) dut (
    .clk(clk), .nRst(nRst), .hit(hif.slave),
    .blocks_left(blocks_left), .level_clear(level_clear),
    .line(line), .new_line(new_line), .write_line(write_line), .next_line(next_line)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] init_row(int r);
    case (r)
      1:                 return 13'h1FF7;
      2:                 return 13'h0001;
      3, 4, 5, 6, 7, 14: return 13'h1FFF;
      default:           return 13'h0000;
    endcase
  endfunction

  // block_state stand-in: rotating row store
  logic [12:0] mem [NR];
  int ptr;
  assign line = mem[ptr];
  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int r = 0; r < NR; r++) mem[r] <= init_row(r);
      ptr <= 0;
    end else if (write_line) mem[ptr] <= new_line;
    else if (next_line)      ptr <= (ptr + 1) % NR;
  end

  // reference grid model
  logic [12:0] rg [NR];
  int rcur, rleft;

  typedef struct {
    logic        hit;
    int          lat;
    int          pulses;
    logic [12:0] nl;
    int          left;
    logic        lvl;
    int          acc;
  } exp_t;
  exp_t q[$];

  int checks = 0, errors = 0;
  int cyc = 0, pulses = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic void ref_reset();
    for (int r = 0; r < NR; r++) rg[r] = init_row(r);
    rcur = 0;
    rleft = INIT;
  endfunction

  function automatic exp_t ref_query(int row, int col);
    exp_t e;
    if (row < NR && col <= 12) begin
      int d = (row - rcur + NR) % NR;
      rcur = row;
      e.hit = rg[row][col];
      if (e.hit) begin
        rg[row][col] = 1'b0;
        if (rleft > 0) rleft--;
      end
      e.nl = rg[row];
      e.lat = d + 1;
      e.pulses = d;
    end else begin
      e.hit = 1'b0;
      e.nl = rg[rcur];
      e.lat = 0;
      e.pulses = 0;
    end
`ifdef BLOCK_HIT_COUNT_EN
    e.left = rleft;
    e.lvl  = (rleft == 0);
`else
    e.left = 0;
    e.lvl  = 1'b0;
`endif
    e.acc = 0;
    return e;
  endfunction

  // monitor
  always @(negedge clk) begin
    if (nRst) begin
      if (write_line || next_line) chk("ctl_exclusive", 32'(write_line && next_line), 0);
      if (next_line) pulses++;
      if (hif.hit_done) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("hit_block", 32'(hif.hit_block), 32'(e.hit));
          chk("latency", 32'(cyc - e.acc), 32'(e.lat));
          chk("next_pulses", 32'(pulses), 32'(e.pulses));
          chk("write_line", 32'(write_line), 32'(e.hit));
          chk("new_line", 32'(new_line), 32'(e.nl));
          chk("blocks_left", 32'(blocks_left), 32'(e.left));
          chk("level_clear", 32'(level_clear), 32'(e.lvl));
        end
        pulses = 0;
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_ready", 32'(hif.hit_ready), 1);
    chk("rst_done", 32'(hif.hit_done), 0);
    chk("rst_block", 32'(hif.hit_block), 0);
    chk("rst_write", 32'(write_line), 0);
    chk("rst_next", 32'(next_line), 0);
    chk("rst_new_line", 32'(new_line), 0);
`ifdef BLOCK_HIT_COUNT_EN
    chk("rst_left", 32'(blocks_left), INIT);
    chk("rst_level", 32'(level_clear), 32'(INIT == 0));
`else
    chk("rst_left", 32'(blocks_left), 0);
    chk("rst_level", 32'(level_clear), 0);
`endif
  endtask

  // called in the negedge phase; returns in the negedge phase of the CHECK cycle
  task automatic query(int row, int col);
    bit acc = 0;
    hif.hit_req = 1'b1;
    hif.hit_row = 4'(row);
    hif.hit_col = 4'(col);
    for (int k = 0; k < 50 && !acc; k++) begin
      if (k > 0) @(negedge clk);
      if (hif.hit_ready) begin
        exp_t e;
        e = ref_query(row, col);
        e.acc = cyc + 1;
        q.push_back(e);
        acc = 1;
      end
    end
    if (!acc) begin
      chk("accept_timeout", 0, 1);
      hif.hit_req = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    hif.hit_row = 4'((row + 1 + $urandom_range(0, 13)) % 16);
    hif.hit_col = 4'((col + 1 + $urandom_range(0, 13)) % 16);
    acc = 0;
    for (int k = 0; k < 40 && !acc; k++) begin
      @(negedge clk);
      if (hif.hit_done) acc = 1;
    end
    if (!acc) chk("done_timeout", 0, 1);
    hif.hit_req = 1'b0;
  endtask

  task automatic apply_reset();
    nRst = 1'b0;
    hif.hit_req = 1'b0;
    q.delete();
    pulses = 0;
    ref_reset();
    #1;
    check_reset_vals();
    @(negedge clk);
    nRst = 1'b1;
  endtask

  initial begin
    hif.hit_req = 1'b0;
    hif.hit_row = 4'd0;
    hif.hit_col = 4'd0;
    ref_reset();
    repeat (2) @(negedge clk);
    check_reset_vals();
    nRst = 1'b1;
    @(negedge clk);

    query(2, 0);
    query(2, 0);
    query(14, 12);
    query(1, 3);
    query(15, 0);
    query(3, 13);

    // reset in the middle of a long seek
    @(negedge clk);
    hif.hit_req = 1'b1;
    hif.hit_row = 4'd13;
    hif.hit_col = 4'd5;
    @(negedge clk);
    hif.hit_row = 4'd4;
    hif.hit_col = 4'd9;
    repeat (3) @(negedge clk);
    chk("midseek_next", 32'(next_line), 1);
    apply_reset();
    query(2, 0);

    for (int i = 0; i < 150; i++) begin
      int r = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 14);
      int c = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 15) : $urandom_range(0, 12);
      query(r, c);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    for (int r = 0; r < NR; r++)
      for (int c = 0; c <= 12; c++) query(r, c);
    for (int i = 0; i < 5; i++) query($urandom_range(0, 14), $urandom_range(0, 12));

    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 0);
`ifdef BLOCK_HIT_COUNT_EN
    chk("final_left", 32'(blocks_left), 0);
    chk("final_level", 32'(level_clear), 1);
`else
    chk("final_left", 32'(blocks_left), 0);
    chk("final_level", 32'(level_clear), 0);
`endif
    for (int r = 0; r < NR; r++) chk("grid_row", 32'(mem[r]), 32'(rg[r]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
